// File: rtl/pipe_datapath.sv
// X/M/W pipeline datapath: operand muxing, X>M>W forwarding,
// load-use interlock, stall and flush.
module pipe_datapath #(
  parameter int XLEN   = 32,
  parameter int NUM_FU = 4,
  parameter int RA_W   = 5,
  localparam int FSW   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   d_valid_i,
  input  logic [RA_W-1:0]        d_rs1_i,
  input  logic [RA_W-1:0]        d_rs2_i,
  input  logic [RA_W-1:0]        d_rd_i,
  input  logic                   d_rd_we_i,
  input  logic                   d_load_i,
  input  logic [1:0]             d_op1_sel_i,
  input  logic [1:0]             d_op2_sel_i,
  input  logic [FSW-1:0]         d_fu_sel_i,
  input  logic [XLEN-1:0]        reg1_data_i,
  input  logic [XLEN-1:0]        reg2_data_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        imm_i,
  input  logic [NUM_FU*XLEN-1:0] fu_out_i,
  input  logic [XLEN-1:0]        mem_rdata_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  output logic [XLEN-1:0]        x_op1_o,
  output logic [XLEN-1:0]        x_op2_o,
  output logic [FSW-1:0]         x_fu_sel_o,
  output logic                   x_valid_o,
  output logic [XLEN-1:0]        m_alu_data_o,
  output logic                   m_valid_o,
  output logic [XLEN-1:0]        w_data_o,
  output logic [RA_W-1:0]        w_rd_o,
  output logic                   w_we_o,
  output logic                   hold_o
);

  logic            x_valid_q, x_rd_we_q, x_load_q;
  logic [RA_W-1:0] x_rd_q;
  logic [FSW-1:0]  x_fu_sel_q;
  logic [XLEN-1:0] x_op1_q, x_op2_q;

  logic            m_valid_q, m_rd_we_q, m_load_q;
  logic [RA_W-1:0] m_rd_q;
  logic [XLEN-1:0] m_alu_data_q;

  logic            w_valid_q, w_rd_we_q;
  logic [RA_W-1:0] w_rd_q;
  logic [XLEN-1:0] w_data_q;

  logic [XLEN-1:0] x_res, m_res;
  logic [XLEN-1:0] op1_d, op2_d;
  logic            hazard, capture;

  // Out-of-range selects yield zero.
  function automatic logic [XLEN-1:0] fu_pick(
    input logic [NUM_FU*XLEN-1:0] b,
    input logic [FSW-1:0]         s
  );
    fu_pick = '0;
    for (int k = 0; k < NUM_FU; k++)
      if (FSW'(k) == s) fu_pick = b[k*XLEN +: XLEN];
  endfunction

  assign x_res = fu_pick(fu_out_i, x_fu_sel_q);
  assign m_res = m_load_q ? mem_rdata_i : m_alu_data_q;

  function automatic logic [XLEN-1:0] fwd(
    input logic [RA_W-1:0] rs,
    input logic [XLEN-1:0] rf
  );
    fwd = rf;
    if (rs != '0) begin
      if (x_valid_q && x_rd_we_q && !x_load_q && x_rd_q == rs)
        fwd = x_res;
      else if (m_valid_q && m_rd_we_q && m_rd_q == rs)
        fwd = m_res;
      else if (w_valid_q && w_rd_we_q && w_rd_q == rs)
        fwd = w_data_q;
    end
  endfunction

  always_comb begin
    op1_d = '0;
    case (d_op1_sel_i)
      2'd0:    op1_d = fwd(d_rs1_i, reg1_data_i);
      2'd1:    op1_d = pc_i;
      default: op1_d = '0;
    endcase
  end

  always_comb begin
    op2_d = '0;
    case (d_op2_sel_i)
      2'd0:    op2_d = fwd(d_rs2_i, reg2_data_i);
      2'd1:    op2_d = imm_i;
      2'd2:    op2_d = XLEN'(4);
      default: op2_d = '0;
    endcase
  end

  assign hazard = x_valid_q && x_load_q && x_rd_we_q
               && (x_rd_q != '0)
               && ((d_op1_sel_i == 2'd0 && d_rs1_i == x_rd_q)
                || (d_op2_sel_i == 2'd0 && d_rs2_i == x_rd_q));
  assign hold_o  = stall_i | hazard;
  assign capture = d_valid_i & ~hold_o & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      x_valid_q  <= 1'b0;
      x_rd_we_q  <= 1'b0;
      x_load_q   <= 1'b0;
      x_rd_q     <= '0;
      x_fu_sel_q <= '0;
      x_op1_q    <= '0;
      x_op2_q    <= '0;
    end else begin
      x_valid_q <= capture;
      if (capture) begin
        x_rd_we_q  <= d_rd_we_i;
        x_load_q   <= d_load_i;
        x_rd_q     <= d_rd_i;
        x_fu_sel_q <= d_fu_sel_i;
        x_op1_q    <= op1_d;
        x_op2_q    <= op2_d;
      end
    end
  end

  // M and W never stall.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_valid_q    <= 1'b0;
      m_rd_we_q    <= 1'b0;
      m_load_q     <= 1'b0;
      m_rd_q       <= '0;
      m_alu_data_q <= '0;
      w_valid_q    <= 1'b0;
      w_rd_we_q    <= 1'b0;
      w_rd_q       <= '0;
      w_data_q     <= '0;
    end else begin
      m_valid_q    <= x_valid_q;
      m_rd_we_q    <= x_rd_we_q;
      m_load_q     <= x_load_q;
      m_rd_q       <= x_rd_q;
      m_alu_data_q <= x_res;
      w_valid_q    <= m_valid_q;
      w_rd_we_q    <= m_rd_we_q;
      w_rd_q       <= m_rd_q;
      w_data_q     <= m_res;
    end
  end

  assign x_op1_o      = x_op1_q;
  assign x_op2_o      = x_op2_q;
  assign x_fu_sel_o   = x_fu_sel_q;
  assign x_valid_o    = x_valid_q;
  assign m_alu_data_o = m_alu_data_q;
  assign m_valid_o    = m_valid_q;
  assign w_data_o     = w_data_q;
  assign w_rd_o       = w_rd_q;
  assign w_we_o       = w_valid_q & w_rd_we_q & (w_rd_q != '0);

endmodule

// File: tb/tb_pipe_datapath.sv
// Randomised and directed bench for pipe_datapath against an
// in-flight instruction list model.
module tb_pipe_datapath;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         d_valid, d_rd_we, d_load, stall, flush;
  logic [4:0]   d_rs1, d_rs2, d_rd;
  logic [1:0]   d_op1_sel, d_op2_sel, d_fu_sel;
  logic [31:0]  reg1, reg2, pc, imm, mem_rdata;
  logic [127:0] fu_out;
  logic [31:0]  x_op1, x_op2, m_alu, w_data;
  logic [1:0]   x_fu_sel;
  logic [4:0]   w_rd;
  logic         x_valid, m_valid, w_we, hold;

  pipe_datapath dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .d_valid_i(d_valid), .d_rs1_i(d_rs1), .d_rs2_i(d_rs2),
    .d_rd_i(d_rd), .d_rd_we_i(d_rd_we), .d_load_i(d_load),
    .d_op1_sel_i(d_op1_sel), .d_op2_sel_i(d_op2_sel),
    .d_fu_sel_i(d_fu_sel), .reg1_data_i(reg1),
    .reg2_data_i(reg2), .pc_i(pc), .imm_i(imm),
    .fu_out_i(fu_out), .mem_rdata_i(mem_rdata),
    .stall_i(stall), .flush_i(flush),
    .x_op1_o(x_op1), .x_op2_o(x_op2), .x_fu_sel_o(x_fu_sel),
    .x_valid_o(x_valid), .m_alu_data_o(m_alu),
    .m_valid_o(m_valid), .w_data_o(w_data), .w_rd_o(w_rd),
    .w_we_o(w_we), .hold_o(hold)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // age 1 = X, 2 = M, 3 = W
  typedef struct {
    logic [4:0]  rd;
    bit          we, ld;
    logic [1:0]  sel;
    logic [31:0] op1, op2, alu, data;
    int          age;
  } ins_t;
  ins_t q[$];

  function automatic logic [31:0] pick(input logic [1:0] s);
    logic [127:0] b;
    b = fu_out;
    return b[s*32 +: 32];
  endfunction

  function automatic int find(input int a);
    foreach (q[i]) if (q[i].age == a) return i;
    return -1;
  endfunction

  // Youngest in-flight producer of rs supplies the value.
  function automatic logic [31:0] src(input logic [4:0] rs,
                                      input logic [31:0] rf);
    int i;
    if (rs == 0) return rf;
    i = find(1);
    if (i >= 0 && q[i].we && !q[i].ld && q[i].rd == rs)
      return pick(q[i].sel);
    i = find(2);
    if (i >= 0 && q[i].we && q[i].rd == rs)
      return q[i].ld ? mem_rdata : q[i].alu;
    i = find(3);
    if (i >= 0 && q[i].we && q[i].rd == rs) return q[i].data;
    return rf;
  endfunction

  function automatic bit mdl_hazard();
    int i;
    i = find(1);
    if (i < 0) return 0;
    if (!(q[i].ld && q[i].we && q[i].rd != 0)) return 0;
    return (d_op1_sel == 0 && d_rs1 == q[i].rd)
        || (d_op2_sel == 0 && d_rs2 == q[i].rd);
  endfunction

  task automatic step();
    bit   hz, cap;
    ins_t n;
    int   i;
    #1;
    hz = mdl_hazard();
    chk("hold", {31'b0, hold}, {31'b0, stall | hz});
    cap = d_valid && !(stall | hz) && !flush;
    n.rd = d_rd; n.we = d_rd_we; n.ld = d_load;
    n.sel = d_fu_sel; n.age = 1; n.alu = 0; n.data = 0;
    case (d_op1_sel)
      2'd0:    n.op1 = src(d_rs1, reg1);
      2'd1:    n.op1 = pc;
      default: n.op1 = 0;
    endcase
    case (d_op2_sel)
      2'd0:    n.op2 = src(d_rs2, reg2);
      2'd1:    n.op2 = imm;
      2'd2:    n.op2 = 32'd4;
      default: n.op2 = 0;
    endcase
    foreach (q[k]) begin
      if (q[k].age == 1) q[k].alu = pick(q[k].sel);
      if (q[k].age == 2) q[k].data = q[k].ld ? mem_rdata : q[k].alu;
    end
    @(posedge clk);
    foreach (q[k]) q[k].age++;
    for (int k = q.size() - 1; k >= 0; k--)
      if (q[k].age > 3) q.delete(k);
    if (cap) q.push_back(n);
    #1;
    i = find(1);
    chk("x_valid", {31'b0, x_valid}, {31'b0, i >= 0});
    if (i >= 0) begin
      chk("x_op1", x_op1, q[i].op1);
      chk("x_op2", x_op2, q[i].op2);
      chk("x_fu_sel", {30'b0, x_fu_sel}, {30'b0, q[i].sel});
    end
    i = find(2);
    chk("m_valid", {31'b0, m_valid}, {31'b0, i >= 0});
    if (i >= 0) chk("m_alu", m_alu, q[i].alu);
    i = find(3);
    if (i >= 0 && q[i].we && q[i].rd != 0) begin
      chk("w_we", {31'b0, w_we}, 32'd1);
      chk("w_rd", {27'b0, w_rd}, {27'b0, q[i].rd});
      chk("w_data", w_data, q[i].data);
    end else begin
      chk("w_we", {31'b0, w_we}, 32'd0);
    end
  endtask

  task automatic idle();
    d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_rd = 0; d_rd_we = 0;
    d_load = 0; d_op1_sel = 2; d_op2_sel = 3; d_fu_sel = 0;
    reg1 = 0; reg2 = 0; pc = 0; imm = 0; fu_out = 0;
    mem_rdata = 0; stall = 0; flush = 0;
  endtask

  task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit we,
                       input bit ld, input logic [1:0] s1,
                       input logic [1:0] s2);
    d_valid = 1; d_rs1 = rs1; d_rs2 = rs2; d_rd = rd;
    d_rd_we = we; d_load = ld; d_op1_sel = s1; d_op2_sel = s2;
    d_fu_sel = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x_valid", {31'b0, x_valid}, 0);
    chk("rst_m_valid", {31'b0, m_valid}, 0);
    chk("rst_w_we", {31'b0, w_we}, 0);
    chk("rst_x_op1", x_op1, 0);
    chk("rst_x_op2", x_op2, 0);
    chk("rst_m_alu", m_alu, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_w_rd", {27'b0, w_rd}, 0);
    chk("rst_hold", {31'b0, hold}, 0);
    rst_n = 1;
    repeat (10) step();

    // X forward: r1 = fu0 result, used the next cycle
    set_d(0, 0, 1, 1, 0, 2, 3);
    step();
    set_d(1, 0, 2, 1, 0, 0, 3);
    reg1 = 32'h1111;
    fu_out = 128'h5;
    step();
    chk("xfwd_op1", x_op1, 32'h5);
    idle();
    step();
    chk("xfwd_w_we", {31'b0, w_we}, 1);
    chk("xfwd_w_rd", {27'b0, w_rd}, 1);
    chk("xfwd_w_data", w_data, 32'h5);
    repeat (3) step();

    // load-use: one hold cycle, bubble, then M forward
    set_d(0, 0, 3, 1, 1, 2, 3);
    step();
    set_d(3, 0, 4, 1, 0, 0, 3);
    #1;
    chk("lu_hold", {31'b0, hold}, 1);
    step();
    chk("lu_bubble", {31'b0, x_valid}, 0);
    mem_rdata = 32'hDEAD;
    step();
    chk("lu_op1", x_op1, 32'hDEAD);
    idle();
    repeat (4) step();

    // writes to r0 never forward or write back
    set_d(0, 0, 0, 1, 0, 2, 3);
    step();
    set_d(0, 0, 5, 1, 0, 0, 3);
    reg1 = 32'h1234;
    fu_out = 128'h77;
    step();
    chk("r0_op1", x_op1, 32'h1234);
    idle();
    step();
    chk("r0_w_we", {31'b0, w_we}, 0);
    repeat (3) step();

    // flush with stall: bubble in X, older instr still moves
    set_d(0, 0, 6, 1, 0, 2, 3);
    step();
    set_d(0, 0, 7, 1, 0, 2, 3);
    flush = 1;
    stall = 1;
    step();
    chk("fl_x_valid", {31'b0, x_valid}, 0);
    chk("fl_m_valid", {31'b0, m_valid}, 1);
    idle();
    repeat (4) step();

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      d_valid = $urandom_range(0, 3) != 0;
      d_rs1 = 5'($urandom_range(0, 3));
      d_rs2 = 5'($urandom_range(0, 3));
      d_rd = 5'($urandom_range(0, 3));
      d_rd_we = $urandom_range(0, 3) != 0;
      d_load = $urandom_range(0, 3) == 0;
      d_op1_sel = 2'($urandom);
      d_op2_sel = 2'($urandom);
      d_fu_sel = 2'($urandom);
      reg1 = $urandom; reg2 = $urandom;
      pc = $urandom; imm = $urandom; mem_rdata = $urandom;
      fu_out = {$urandom, $urandom, $urandom, $urandom};
      stall = $urandom_range(0, 7) == 0;
      flush = $urandom_range(0, 7) == 0;
      step();
    end

    // reset with three instructions in flight
    idle();
    for (int k = 1; k <= 3; k++) begin
      set_d(0, 0, 5'(k), 1, 0, 2, 3);
      fu_out = 128'h9;
      step();
    end
    #2;
    rst_n = 0;
    q.delete();
    #1;
    chk("mr_x_valid", {31'b0, x_valid}, 0);
    chk("mr_m_valid", {31'b0, m_valid}, 0);
    chk("mr_w_we", {31'b0, w_we}, 0);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
